// File: rtl/crtc_pkg.sv
// Shared definitions for the 6845-style CRT controller: register indices,
// blink-mode encodings, vertical phase states and per-register write masks.
package crtc_pkg;

  localparam logic [4:0] R_HTOTAL = 5'd0;
  localparam logic [4:0] R_HDISP  = 5'd1;
  localparam logic [4:0] R_HSPOS  = 5'd2;
  localparam logic [4:0] R_SYNCW  = 5'd3;
  localparam logic [4:0] R_VTOTAL = 5'd4;
  localparam logic [4:0] R_VADJ   = 5'd5;
  localparam logic [4:0] R_VDISP  = 5'd6;
  localparam logic [4:0] R_VSPOS  = 5'd7;
  localparam logic [4:0] R_ILACE  = 5'd8;
  localparam logic [4:0] R_MAXRA  = 5'd9;
  localparam logic [4:0] R_CURS   = 5'd10;
  localparam logic [4:0] R_CURE   = 5'd11;
  localparam logic [4:0] R_STARTH = 5'd12;
  localparam logic [4:0] R_STARTL = 5'd13;
  localparam logic [4:0] R_CURH   = 5'd14;
  localparam logic [4:0] R_CURL   = 5'd15;

  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {
    BLINK_ON  = 2'b00,
    BLINK_OFF = 2'b01,
    BLINK_F16 = 2'b10,
    BLINK_F32 = 2'b11
  } blink_e;

  typedef enum logic {
    V_NORMAL = 1'b0,
    V_ADJUST = 1'b1
  } vphase_e;

  // Implemented bits of each register; unimplemented bits store as zero.
  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    logic [7:0] m;
    case (idx)
      4'd4, 4'd6, 4'd7, 4'd10: m = 8'h7F;
      4'd5, 4'd9, 4'd11:       m = 8'h1F;
      4'd12, 4'd14:            m = 8'h3F;
      default:                 m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/crtc_regfile.sv
// CPU-visible register file: address latch, R0-R15, write decode, read mux.
module crtc_regfile
  import crtc_pkg::*;
(
  input  logic                          clk2MHz,
  input  logic                          RESET,
  input  logic                          nCS,
  input  logic                          RS,
  input  logic                          RnW,
  input  logic [7:0]                    DATA,
  output logic [7:0]                    DATA_out,
  output logic [NUM_REGS-1:0][7:0]      regs
);

  logic [4:0] addr;

  // CPU writes land on any clock edge, regardless of the character enable.
  always_ff @(posedge clk2MHz or posedge RESET) begin
    if (RESET) begin
      addr <= '0;
      regs <= '0;
    end else if (!nCS && !RnW) begin
      if (!RS)
        addr <= DATA[4:0];
      else if (!addr[4])
        regs[addr[3:0]] <= DATA & reg_mask(addr[3:0]);
    end
  end

  // Only the cursor address is readable; everything else reads as zero.
  always_comb begin
    DATA_out = '0;
    if (RS && (addr == R_CURH || addr == R_CURL))
      DATA_out = regs[addr[3:0]];
  end

endmodule

// File: rtl/crtc6845.sv
// Character-cell raster timing: counters, memory/raster address, syncs,
// display enable and cursor. All outputs are registered and advance on
// CHAR_EN; they hold while CHAR_EN is low.
module crtc6845
  import crtc_pkg::*;
(
  input  logic        clk2MHz,
  input  logic        RESET,
  input  logic        CHAR_EN,
  input  logic        nCS,
  input  logic        RS,
  input  logic        RnW,
  input  logic [7:0]  DATA,
  output logic [7:0]  DATA_out,
  output logic [13:0] MA,
  output logic [4:0]  RA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISEN,
  output logic        CURSOR
);

  logic [NUM_REGS-1:0][7:0] regs;

  crtc_regfile u_regs (
    .clk2MHz  (clk2MHz),
    .RESET    (RESET),
    .nCS      (nCS),
    .RS       (RS),
    .RnW      (RnW),
    .DATA     (DATA),
    .DATA_out (DATA_out),
    .regs     (regs)
  );

  // Register fields at their implemented widths.
  logic [7:0] r_htotal, r_hdisp, r_hspos;
  logic [3:0] r_hwidth, r_vwidth;
  logic [6:0] r_vtotal, r_vdisp, r_vspos;
  logic [4:0] r_vadj, r_maxra, r_curstart, r_curend;
  logic [1:0] r_blink;
  logic [13:0] r_start, r_curaddr;

  assign r_htotal   = regs[R_HTOTAL[3:0]];
  assign r_hdisp    = regs[R_HDISP[3:0]];
  assign r_hspos    = regs[R_HSPOS[3:0]];
  assign r_hwidth   = regs[R_SYNCW[3:0]][3:0];
  assign r_vwidth   = regs[R_SYNCW[3:0]][7:4];
  assign r_vtotal   = regs[R_VTOTAL[3:0]][6:0];
  assign r_vadj     = regs[R_VADJ[3:0]][4:0];
  assign r_vdisp    = regs[R_VDISP[3:0]][6:0];
  assign r_vspos    = regs[R_VSPOS[3:0]][6:0];
  assign r_maxra    = regs[R_MAXRA[3:0]][4:0];
  assign r_curstart = regs[R_CURS[3:0]][4:0];
  assign r_blink    = regs[R_CURS[3:0]][6:5];
  assign r_curend   = regs[R_CURE[3:0]][4:0];
  assign r_start    = {regs[R_STARTH[3:0]][5:0], regs[R_STARTL[3:0]]};
  assign r_curaddr  = {regs[R_CURH[3:0]][5:0], regs[R_CURL[3:0]]};

  // R8 is stored for software but drives nothing; masked bits are always 0.
  logic unused_bits;
  assign unused_bits = ^{regs[4][7], regs[5][7:5], regs[6][7], regs[7][7],
                         regs[8], regs[9][7:5], regs[10][7], regs[11][7:5],
                         regs[12][7:6], regs[14][7:6]};

  // Timing state.
  logic [7:0]  hc;
  logic [4:0]  ra;
  logic [6:0]  row;
  logic [13:0] line_addr;
  logic [4:0]  frame;
  vphase_e     vph, vph_n;
  logic        in_adj, in_adj_n;

  logic        line_end;
  assign line_end = (hc == r_htotal);

  // Vertical phase state register.
  always_ff @(posedge clk2MHz or posedge RESET) begin
    if (RESET)        vph <= V_NORMAL;
    else if (CHAR_EN) vph <= vph_n;
  end

  // Vertical phase next state: enter adjust after the last row when R5 != 0.
  always_comb begin
    vph_n = vph;
    if (line_end) begin
      case (vph)
        V_NORMAL: if (ra == r_maxra && row == r_vtotal && r_vadj != 5'd0)
                    vph_n = V_ADJUST;
        V_ADJUST: if (ra == r_vadj - 5'd1)
                    vph_n = V_NORMAL;
        default:  vph_n = V_NORMAL;
      endcase
    end
  end

  // Vertical phase decode for current and upcoming position.
  always_comb begin
    in_adj   = (vph == V_ADJUST);
    in_adj_n = (vph_n == V_ADJUST);
  end

  // Next character position.
  logic [7:0]  hc_n;
  logic [4:0]  ra_n;
  logic [6:0]  row_n;
  logic [13:0] line_n;
  logic [4:0]  frame_n;
  logic        eof;

  // Counter chain: HC -> scanline -> row/adjust -> end of frame.
  always_comb begin
    hc_n    = line_end ? 8'd0 : hc + 8'd1;
    ra_n    = ra;
    row_n   = row;
    line_n  = line_addr;
    frame_n = frame;
    eof     = 1'b0;
    if (line_end) begin
      if (!in_adj) begin
        if (ra == r_maxra) begin
          line_n = line_addr + {6'd0, r_hdisp};
          ra_n   = 5'd0;
          if (row == r_vtotal) begin
            if (r_vadj == 5'd0) eof = 1'b1;
          end else begin
            row_n = row + 7'd1;
          end
        end else begin
          ra_n = ra + 5'd1;
        end
      end else if (ra == r_vadj - 5'd1) begin
        eof = 1'b1;
      end else begin
        ra_n = ra + 5'd1;
      end
      if (eof) begin
        row_n   = 7'd0;
        ra_n    = 5'd0;
        line_n  = r_start;
        frame_n = frame + 5'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk2MHz or posedge RESET) begin
    if (RESET) begin
      hc        <= '0;
      ra        <= '0;
      row       <= '0;
      line_addr <= '0;
      frame     <= '0;
    end else if (CHAR_EN) begin
      hc        <= hc_n;
      ra        <= ra_n;
      row       <= row_n;
      line_addr <= line_n;
      frame     <= frame_n;
    end
  end

  assign RA = ra;

  // Display enable, address and cursor for the upcoming position.
  logic [13:0] ma_n;
  logic        disen_n, blink_n, cursor_n;

  always_comb begin
    ma_n    = line_n + {6'd0, hc_n};
    disen_n = (hc_n < r_hdisp) && (row_n < r_vdisp) && !in_adj_n;
    case (blink_e'(r_blink))
      BLINK_ON:  blink_n = 1'b1;
      BLINK_OFF: blink_n = 1'b0;
      BLINK_F16: blink_n = frame_n[3];
      default:   blink_n = frame_n[4];
    endcase
    cursor_n = disen_n && (ma_n == r_curaddr) && blink_n &&
               (ra_n >= r_curstart) && (ra_n <= r_curend);
  end

  // Sync pulse widths; a zero field means 16. Compares use >= so that a
  // width reprogrammed below the elapsed count ends the pulse at once.
  logic [4:0] hw_len, vw_len, hs_cnt, vs_cnt, hs_cnt_n, vs_cnt_n;
  logic       hsync_n, vsync_n, hs_done, vs_done;

  assign hw_len = (r_hwidth == 4'd0) ? 5'd16 : {1'b0, r_hwidth};
  assign vw_len = (r_vwidth == 4'd0) ? 5'd16 : {1'b0, r_vwidth};

  // HSYNC counts characters; VSYNC counts scanlines and only moves at line end.
  always_comb begin
    hs_done  = HSYNC && (hs_cnt >= hw_len);
    hsync_n  = 1'b0;
    hs_cnt_n = hs_cnt;
    if (hc_n == r_hspos && (!HSYNC || hs_done)) begin
      hsync_n  = 1'b1;
      hs_cnt_n = 5'd1;
    end else if (HSYNC && !hs_done) begin
      hsync_n  = 1'b1;
      hs_cnt_n = hs_cnt + 5'd1;
    end

    vs_done  = VSYNC && (vs_cnt >= vw_len);
    vsync_n  = VSYNC;
    vs_cnt_n = vs_cnt;
    if (line_end) begin
      if (ra_n == 5'd0 && row_n == r_vspos && !in_adj_n && (!VSYNC || vs_done)) begin
        vsync_n  = 1'b1;
        vs_cnt_n = 5'd1;
      end else if (VSYNC && !vs_done) begin
        vs_cnt_n = vs_cnt + 5'd1;
      end else begin
        vsync_n  = 1'b0;
      end
    end
  end

  // Registered outputs and sync counters.
  always_ff @(posedge clk2MHz or posedge RESET) begin
    if (RESET) begin
      MA     <= '0;
      DISEN  <= 1'b0;
      CURSOR <= 1'b0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      hs_cnt <= '0;
      vs_cnt <= '0;
    end else if (CHAR_EN) begin
      MA     <= ma_n;
      DISEN  <= disen_n;
      CURSOR <= cursor_n;
      HSYNC  <= hsync_n;
      VSYNC  <= vsync_n;
      hs_cnt <= hs_cnt_n;
      vs_cnt <= vs_cnt_n;
    end
  end

endmodule
